// File: rtl/reg_bank_sb.sv
// Register bank with two combinational read ports, one synchronous write port,
// optional hardwired zero register, write-to-read bypass and a per-register busy scoreboard.
module reg_bank_sb #(
   parameter int DW       = 32,
   parameter int DEPTH    = 32,
   parameter int AW       = $clog2(DEPTH),
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] ra1,
   input  logic [AW-1:0] ra2,
   output logic [DW-1:0] rd1,
   output logic [DW-1:0] rd2,
   output logic          rd1_busy,
   output logic          rd2_busy,
   input  logic          regwrite,
   input  logic          regdst,
   input  logic [AW-1:0] wa,
   input  logic [DW-1:0] wd,
   input  logic          iss_valid,
   input  logic [AW-1:0] iss_addr,
   output logic [AW:0]   busy_cnt
);

   logic [AW-1:0]    waddr;
   logic [DW-1:0]    regs [DEPTH];
   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busy_nxt;
   logic [DEPTH-1:0] wr_sel;
   logic [DEPTH-1:0] iss_sel;
   logic             hit1;
   logic             hit2;
   logic             zero1;
   logic             zero2;

   function automatic logic [AW:0] popcount(input logic [DEPTH-1:0] v);
      logic [AW:0] n;
      n = '0;
      for (int i = 0; i < DEPTH; i++) n = n + {{AW{1'b0}}, v[i]};
      return n;
   endfunction

   assign waddr = regdst ? wa : ra2;

   // One-hot write and issue decodes; both are gated by their enables so X addresses stay harmless.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      wr_sel  = '0;
      iss_sel = '0;
      for (int i = 0; i < DEPTH; i++) begin
         wr_sel[i]  = regwrite  && (waddr == AW'(i))    && !(ZERO_REG && i == 0);
         iss_sel[i] = iss_valid && (iss_addr == AW'(i)) && !(ZERO_REG && i == 0);
      end
   end

   // Set after clear: a simultaneous issue to the written register keeps it busy.
   assign busy_nxt = (busy & ~wr_sel) | iss_sel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the array is reset explicitly because the clear is functional; this keeps it in flops, not RAM.
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) regs[i] <= wd;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         // NOTE: state updates use <= so busy_cnt samples the pre-edge busy vector, giving its one-cycle lag.
         busy     <= busy_nxt;
         busy_cnt <= popcount(busy);
      end
   end

   assign zero1 = ZERO_REG && (ra1 == '0);
   assign zero2 = ZERO_REG && (ra2 == '0);
   assign hit1  = BYPASS && regwrite && (waddr == ra1) && !zero1;
   assign hit2  = BYPASS && regwrite && (waddr == ra2) && !zero2;

   // Reads are forced to zero during reset so a bypassed wd cannot leak out.
   always_comb begin
      rd1      = '0;
      rd2      = '0;
      rd1_busy = 1'b0;
      rd2_busy = 1'b0;
      if (rst_n) begin
         if (hit1)        rd1 = wd;
         else if (!zero1) rd1 = regs[ra1];
         if (hit2)        rd2 = wd;
         else if (!zero2) rd2 = regs[ra2];
         rd1_busy = busy[ra1] && !hit1;
         rd2_busy = busy[ra2] && !hit2;
      end
   end

endmodule

// File: tb/tb_reg_bank_sb.sv
// Scoreboard bench: two DUT variants (zero-reg+bypass, plain) share stimulus and are checked
// against a behavioural register-file model via an expectation queue drained by a monitor.
module tb_reg_bank_sb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  ra1 = '0, ra2 = '0, wa = '0, iss_addr = '0;
   logic [31:0] wd = '0;
   logic        regwrite = 1'b0, regdst = 1'b0, iss_valid = 1'b0;

   logic [31:0] rd1_m, rd2_m, rd1_a, rd2_a;
   logic        b1_m, b2_m, b1_a, b2_a;
   logic [5:0]  cnt_m, cnt_a;

   always #5 clk = ~clk;

   reg_bank_sb u_dut (
      .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_m), .rd2(rd2_m),
      .rd1_busy(b1_m), .rd2_busy(b2_m), .regwrite(regwrite), .regdst(regdst), .wa(wa), .wd(wd),
      .iss_valid(iss_valid), .iss_addr(iss_addr), .busy_cnt(cnt_m)
   );

   reg_bank_sb #(.ZERO_REG(1'b0), .BYPASS(1'b0)) u_alt (
      .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a),
      .rd1_busy(b1_a), .rd2_busy(b2_a), .regwrite(regwrite), .regdst(regdst), .wa(wa), .wd(wd),
      .iss_valid(iss_valid), .iss_addr(iss_addr), .busy_cnt(cnt_a)
   );

   typedef struct packed {
      logic [1:0][31:0] rd1;
      logic [1:0][31:0] rd2;
      logic [1:0]       b1;
      logic [1:0]       b2;
      logic [1:0][5:0]  cnt;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    passed = 0;
   int    total  = 0;

   // Reference model: variant 0 has zero register and bypass, variant 1 has neither.
   logic [31:0] m_regs [2][32];
   bit          m_busy [2][32];
   int          m_cnt  [2];

   function automatic bit has_zero(int v); return v == 0; endfunction
   function automatic bit has_byp(int v);  return v == 0; endfunction

   function automatic logic [4:0] eff_waddr();
      return regdst ? wa : ra2;
   endfunction

   function automatic logic [31:0] model_rd(int v, logic [4:0] ra);
      if (!rst_n) return '0;
      if (has_zero(v) && ra == 0) return '0;
      if (has_byp(v) && regwrite && eff_waddr() == ra) return wd;
      return m_regs[v][ra];
   endfunction

   function automatic logic model_busy(int v, logic [4:0] ra);
      if (!rst_n) return 1'b0;
      return m_busy[v][ra] && !(has_byp(v) && regwrite && eff_waddr() == ra);
   endfunction

   task automatic model_clear();
      for (int v = 0; v < 2; v++) begin
         m_cnt[v] = 0;
         for (int r = 0; r < 32; r++) begin
            m_regs[v][r] = '0;
            m_busy[v][r] = 1'b0;
         end
      end
   endtask

   task automatic model_step();
      logic [4:0] w;
      w = eff_waddr();
      for (int v = 0; v < 2; v++) begin
         int n;
         n = 0;
         for (int r = 0; r < 32; r++) if (m_busy[v][r]) n++;
         m_cnt[v] = n;
         if (regwrite && !(has_zero(v) && w == 0)) m_regs[v][w] = wd;
         if (regwrite) m_busy[v][w] = 1'b0;
         if (iss_valid && !(has_zero(v) && iss_addr == 0)) m_busy[v][iss_addr] = 1'b1;
      end
   endtask

   task automatic push_exp(string nm);
      exp_t e;
      for (int v = 0; v < 2; v++) begin
         e.rd1[v] = model_rd(v, ra1);
         e.rd2[v] = model_rd(v, ra2);
         e.b1[v]  = model_busy(v, ra1);
         e.b2[v]  = model_busy(v, ra2);
         e.cnt[v] = rst_n ? 6'(m_cnt[v]) : 6'd0;
      end
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic cycle(string nm, bit we, bit dst, logic [4:0] a_wa, logic [31:0] a_wd,
                        logic [4:0] a1, logic [4:0] a2, bit iv, logic [4:0] ia);
      @(negedge clk);
      #1;
      regwrite = we; regdst = dst; wa = a_wa; wd = a_wd;
      ra1 = a1; ra2 = a2; iss_valid = iv; iss_addr = ia;
      push_exp(nm);
      @(posedge clk);
      #1;
      model_step();
   endtask

   task automatic idle(string nm, logic [4:0] a1, logic [4:0] a2);
      cycle(nm, 1'b0, 1'b1, 5'd0, 32'd0, a1, a2, 1'b0, 5'd0);
   endtask

   // Asserts reset mid-cycle with the current inputs still applied, holds it across one edge.
   task automatic do_reset(string nm);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      model_clear();
      push_exp(nm);
      @(posedge clk);
      @(negedge clk);
      #1;
      regwrite = 1'b0;
      iss_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   // Monitor: outputs are combinational, so each queued expectation is compared mid-cycle.
   initial begin
      exp_t  e;
      string nm;
      forever begin
         @(negedge clk);
         #3;
         while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check({nm, ".rd1"},      rd1_m,        e.rd1[0]);
            check({nm, ".rd2"},      rd2_m,        e.rd2[0]);
            check({nm, ".rd1_busy"}, 32'(b1_m),    32'(e.b1[0]));
            check({nm, ".rd2_busy"}, 32'(b2_m),    32'(e.b2[0]));
            check({nm, ".busy_cnt"}, 32'(cnt_m),   32'(e.cnt[0]));
            check({nm, ".alt_rd1"},  rd1_a,        e.rd1[1]);
            check({nm, ".alt_rd2"},  rd2_a,        e.rd2[1]);
            check({nm, ".alt_busy1"}, 32'(b1_a),   32'(e.b1[1]));
            check({nm, ".alt_busy2"}, 32'(b2_a),   32'(e.b2[1]));
            check({nm, ".alt_cnt"},  32'(cnt_a),   32'(e.cnt[1]));
         end
      end
   end

   initial begin
      int wait_cyc;
      model_clear();
      do_reset("reset_init");

      // Reset clears storage asynchronously and discards a write pending at the reset edge.
      cycle("wr5", 1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd1, 1'b0, 5'd0);
      idle("rd5", 5'd5, 5'd0);
      cycle("wr5_again", 1'b1, 1'b1, 5'd5, 32'h0BAD_F00D, 5'd5, 5'd1, 1'b1, 5'd6);
      do_reset("reset_mid");
      idle("rd5_after_rst", 5'd5, 5'd6);

      // Zero register.
      cycle("wr0", 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd1, 5'd2, 1'b0, 5'd0);
      idle("rd0", 5'd0, 5'd0);

      // Bypass on both ports.
      cycle("pre7", 1'b1, 1'b1, 5'd7, 32'hAAAA_0007, 5'd0, 5'd0, 1'b0, 5'd0);
      cycle("byp7", 1'b1, 1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd7, 1'b0, 5'd0);
      idle("rd7", 5'd7, 5'd7);

      // regdst=0: write goes to ra2, wa ignored.
      cycle("wr_ra2", 1'b1, 1'b0, 5'd12, 32'h0000_0055, 5'd9, 5'd9, 1'b0, 5'd0);
      idle("rd9_12", 5'd9, 5'd12);

      // Scoreboard set / clear / issue+write collision.
      cycle("iss3", 1'b0, 1'b1, 5'd0, 32'd0, 5'd3, 5'd4, 1'b1, 5'd3);
      for (int i = 0; i < 3; i++) idle("idle3", 5'd3, 5'd4);
      cycle("wr3", 1'b1, 1'b1, 5'd3, 32'h0000_0333, 5'd3, 5'd4, 1'b0, 5'd0);
      idle("post_wr3", 5'd3, 5'd4);
      idle("cnt_zero", 5'd3, 5'd4);
      cycle("iss_wr3", 1'b1, 1'b1, 5'd3, 32'h0000_3333, 5'd3, 5'd3, 1'b1, 5'd3);
      idle("still3", 5'd3, 5'd4);
      idle("still3b", 5'd3, 5'd4);

      // Fill every register, then try claiming register 0.
      for (int a = 1; a < 32; a++) cycle("fill", 1'b0, 1'b1, 5'd0, 32'd0, 5'(a), 5'd0, 1'b1, 5'(a));
      idle("full", 5'd31, 5'd1);
      idle("full_cnt", 5'd0, 5'd30);
      cycle("iss0", 1'b0, 1'b1, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd0);
      idle("after_iss0", 5'd0, 5'd1);
      idle("after_iss0b", 5'd0, 5'd2);

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         cycle("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom),
               32'($urandom), 5'($urandom), 5'($urandom),
               ($urandom_range(0, 9) < 3), 5'($urandom));
      end
      idle("final", 5'd3, 5'd17);

      wait_cyc = 0;
      while (exp_q.size() > 0 && wait_cyc < 20) begin
         @(negedge clk);
         wait_cyc++;
      end
      #5;
      check("drain", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
